ook_keyer: RTL and testbench
============================

OOK_KEYER -- requirements
Module: ook_keyer

Interface
REQ-001 Parameter PATTERN_W, default 32, is the pattern register width in bits.
REQ-002 Parameter DIV_W, default 24, is the width of the symbol-period divisor.
REQ-003 Parameter GAP_UNITS, default 7, is the number of symbol periods of silence between repeats.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 CLK  in  1  single system clock, 50 MHz PLL core output.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 start  in  1  request to begin keying; sampled only in IDLE.
REQ-008 abort  in  1  stop keying immediately; priority over all other inputs except RST.
REQ-009 pattern  in  PATTERN_W  on/off symbol sequence; bit 0 is sent first.
REQ-010 length  in  6  number of symbols to send, 1..PATTERN_W.
REQ-011 unit_div  in  DIV_W  symbol period minus one, in CLK cycles.
REQ-012 repeat  in  1  loop the pattern with a gap until aborted.
REQ-013 busy  out  1  high in SEND and GAP states.
REQ-014 done  out  1  one-cycle pulse on normal completion.
REQ-015 key  out  1  current symbol level (registered).
REQ-016 carrier_out  out  1  CLK/2 square wave gated by key, for the RF test pin.
REQ-017 led  out  1  copy of key, for the user LED.

Function
REQ-018 States SHALL be IDLE, SEND and GAP.
REQ-019 In IDLE, start=1 with length!=0 SHALL latch pattern, length and unit_div, then enter SEND at symbol index 0 on the next edge.
REQ-020 start with length=0 SHALL be ignored; busy stays 0 and done stays 0.
REQ-021 A length above PATTERN_W SHALL be clamped to PATTERN_W at latch time.
REQ-022 Latency: start is sampled at edge t; busy=1 and key=pattern[0] are visible from cycle t+1.
REQ-023 Each symbol SHALL hold key for exactly unit_div+1 cycles; unit_div=0 gives one cycle per symbol.
REQ-024 Symbols SHALL be sent in index order 0..length-1, with key=latched_pattern[index].
REQ-025 On the end of the last symbol with the latched repeat=0, the block SHALL enter IDLE, drive key=0, and pulse done for one cycle in that first IDLE cycle.
REQ-026 On the end of the last symbol with the latched repeat=1, the block SHALL enter GAP with key=0 for GAP_UNITS*(unit_div+1) cycles, then enter SEND at index 0; done SHALL NOT pulse.
REQ-027 Inputs pattern, length, unit_div and repeat SHALL be ignored while busy; only the latched copies are used.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort=1 in SEND or GAP SHALL enter IDLE on the next edge with key=0 and no done pulse.
REQ-030 abort=1 together with start in IDLE SHALL win; the start is dropped.
REQ-031 carrier_out SHALL equal a free-running toggle flop ANDed with key, registered; it is 0 whenever key=0.
REQ-032 The symbol counter and gap counter SHALL NOT wrap within a symbol; the wrap point is defined only by unit_div.

Reset
REQ-033 RST=1 at an edge SHALL force IDLE and clear key, carrier_out, led, busy, done, the toggle flop and all counters.
REQ-034 Reset mid-SEND or mid-GAP SHALL abort without a done pulse; after reset, outputs are 0 from the next cycle.

Structure
REQ-035 Package ook_pkg SHALL hold the state enum (IDLE/SEND/GAP) and the default constants PATTERN_W and GAP_UNITS.
REQ-036 Sub-module ook_unit_timer SHALL implement the loadable down-counter that produces a one-cycle tick every unit_div+1 cycles; it is reused for GAP timing.
REQ-037 All outputs SHALL be registered; there are no combinational input-to-output paths.

Verification
REQ-038 Single-bit: pattern=0b1, length=1, unit_div=0 -> key high for exactly 1 cycle, done pulses the next cycle, busy high for 1 cycle.
REQ-039 Timed pattern: pattern=0b10101, length=5, unit_div=3, repeat=0 -> key sequence 1,0,1,0,1 with each level held 4 cycles; done pulses exactly 20 cycles after busy rises.
REQ-040 Repeat: pattern=0b11, length=2, unit_div=1, repeat=1 -> key high 4 cycles, low 14 cycles, high 4 cycles, and so on; no done pulse; abort mid-GAP -> IDLE next cycle.
REQ-041 Edge inputs: length=0 -> no busy; length=40 -> exactly 32 symbols sent; start during busy with a new pattern -> original pattern keeps playing unchanged.
REQ-042 Reset and abort: RST asserted at symbol 3 of 8 -> all outputs 0 the next cycle and no done; abort and start in the same IDLE cycle -> no busy.
REQ-043 Carrier: while key=1, carrier_out alternates every cycle; while key=0, carrier_out is constant 0.

Source files
------------

// File: rtl/ook_pkg.sv
// Shared types and default constants for the on/off keying transmitter.
package ook_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int unsigned PATTERN_W_DEF = 32;
    localparam int unsigned GAP_UNITS_DEF = 7;
    localparam int unsigned LEN_W         = 6;

endpackage

// File: rtl/ook_unit_timer.sv
// Loadable down-counter: ticks once every period+1 cycles while running.
module ook_unit_timer #(
    parameter int unsigned DIV_W = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic [DIV_W-1:0] period,
    input  logic             run,
    output logic             tick_c
);

    logic [DIV_W-1:0] count;

    assign tick_c = run && (count == '0);

    // Reload on the tick so consecutive units are back to back without a gap cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run) begin
            if (count == '0) begin
                count <= period;
            end else begin
                count <= count - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/ook_keyer.sv
// On/off keyer: plays a latched symbol pattern at a programmable symbol rate,
// optionally looping with a fixed silent gap, with a gated CLK/2 carrier.
module ook_keyer
    import ook_pkg::*;
#(
    parameter int unsigned PATTERN_W = PATTERN_W_DEF,
    parameter int unsigned DIV_W     = 24,
    parameter int unsigned GAP_UNITS = GAP_UNITS_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [LEN_W-1:0]     length,
    input  logic [DIV_W-1:0]     unit_div,
    input  logic                 repeat_en,
    output logic                 busy,
    output logic                 done,
    output logic                 key,
    output logic                 carrier_out,
    output logic                 led
);

    localparam int unsigned IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
    localparam int unsigned GAP_W = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;

    state_t               state;
    logic [PATTERN_W-1:0] pat_q;
    logic [LEN_W-1:0]     len_q;
    logic [DIV_W-1:0]     div_q;
    logic                 rpt_q;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     nxt_idx;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 tog;
    logic                 tick;
    logic                 start_ok;
    logic                 last;
    logic                 key_nxt;
    logic [LEN_W-1:0]     len_clamp;

    assign start_ok  = (state == IDLE) && start && !abort && (length != '0);
    assign len_clamp = (length > LEN_W'(PATTERN_W)) ? LEN_W'(PATTERN_W) : length;
    assign last      = (LEN_W'(idx) == (len_q - LEN_W'(1)));
    assign nxt_idx   = idx + IDX_W'(1);

    ook_unit_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (start_ok),
        .load_val (unit_div),
        .period   (div_q),
        .run      (state != IDLE),
        .tick_c   (tick)
    );

    // Level the key takes after this edge; key, led and carrier all register it together.
    always_comb begin
        key_nxt = 1'b0;
        case (state)
            IDLE: key_nxt = start_ok ? pattern[0] : 1'b0;
            SEND: begin
                if (abort) begin
                    key_nxt = 1'b0;
                end else if (tick) begin
                    key_nxt = last ? 1'b0 : pat_q[nxt_idx];
                end else begin
                    key_nxt = pat_q[idx];
                end
            end
            GAP: key_nxt = (!abort && tick && (gap_cnt == '0)) ? pat_q[0] : 1'b0;
            default: key_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            div_q       <= '0;
            rpt_q       <= 1'b0;
            idx         <= '0;
            gap_cnt     <= '0;
            tog         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            key         <= 1'b0;
            led         <= 1'b0;
            carrier_out <= 1'b0;
        end else begin
            tog         <= ~tog;
            key         <= key_nxt;
            led         <= key_nxt;
            carrier_out <= key_nxt & ~tog;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        pat_q <= pattern;
                        len_q <= len_clamp;
                        div_q <= unit_div;
                        rpt_q <= repeat_en;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tick) begin
                        if (last) begin
                            busy    <= rpt_q;
                            done    <= ~rpt_q;
                            gap_cnt <= GAP_W'(GAP_UNITS - 1);
                            state   <= rpt_q ? GAP : IDLE;
                        end else begin
                            idx <= nxt_idx;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tick) begin
                        if (gap_cnt == '0) begin
                            idx   <= '0;
                            state <= SEND;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ook_keyer.sv
// Directed bench for ook_keyer; outputs are sampled on the falling edge.
module tb_ook_keyer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        abort;
    logic [31:0] pattern;
    logic [5:0]  length;
    logic [23:0] unit_div;
    logic        repeat_en;
    logic        busy;
    logic        done;
    logic        key;
    logic        carrier_out;
    logic        led;

    int checks   = 0;
    int failures = 0;

    ook_keyer dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .abort       (abort),
        .pattern     (pattern),
        .length      (length),
        .unit_div    (unit_div),
        .repeat_en   (repeat_en),
        .busy        (busy),
        .done        (done),
        .key         (key),
        .carrier_out (carrier_out),
        .led         (led)
    );

    always #5 CLK = ~CLK;

    // Called on a falling edge; returns on the falling edge of the first busy cycle.
    task automatic start_job(input logic [31:0] p, input logic [5:0] l,
                             input logic [23:0] d, input logic r);
        pattern   = p;
        length    = l;
        unit_div  = d;
        repeat_en = r;
        start     = 1'b1;
        @(negedge CLK);
        start     = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0;
        length = '0; unit_div = '0; repeat_en = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({busy, done, key, carrier_out, led} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=00000", {busy, done, key, carrier_out, led});
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({busy, done, key} !== 3'b0) begin
            failures++;
            $display("FAIL post_reset_idle got=%b want=000", {busy, done, key});
        end
    endtask

    task automatic test_single_bit();
        start_job(32'h1, 6'd1, 24'd0, 1'b0);
        checks++;
        if ({busy, key, led, done} !== 4'b1110) begin
            failures++;
            $display("FAIL single_first got=%b want=1110", {busy, key, led, done});
        end
        @(negedge CLK);
        checks++;
        if ({busy, key, done} !== 3'b001) begin
            failures++;
            $display("FAIL single_done got=%b want=001", {busy, key, done});
        end
        @(negedge CLK);
        checks++;
        if ({busy, key, done} !== 3'b000) begin
            failures++;
            $display("FAIL single_after got=%b want=000", {busy, key, done});
        end
    endtask

    task automatic test_timed_pattern();
        logic [4:0] p;
        logic       exp_k;
        logic       prev_k;
        logic       prev_c;
        p = 5'b10101;
        prev_k = 1'b0;
        prev_c = 1'b0;
        start_job(32'(p), 6'd5, 24'd3, 1'b0);
        for (int c = 0; c < 20; c++) begin
            exp_k = p[c / 4];
            checks++;
            if (key !== exp_k || led !== exp_k || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL timed_c%0d got key=%b led=%b busy=%b done=%b want key=%b busy=1 done=0",
                         c, key, led, busy, done, exp_k);
            end
            checks++;
            if (!exp_k && carrier_out !== 1'b0) begin
                failures++;
                $display("FAIL timed_carrier_off_c%0d got=%b want=0", c, carrier_out);
            end else if (exp_k && prev_k && carrier_out !== ~prev_c) begin
                failures++;
                $display("FAIL timed_carrier_toggle_c%0d got=%b want=%b", c, carrier_out, ~prev_c);
            end
            prev_k = exp_k;
            prev_c = carrier_out;
            @(negedge CLK);
        end
        checks++;
        if ({busy, key, done, carrier_out} !== 4'b0010) begin
            failures++;
            $display("FAIL timed_done_at_20 got=%b want=0010", {busy, key, done, carrier_out});
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL timed_done_width got=%b want=0", done);
        end
    endtask

    task automatic test_repeat_abort();
        logic exp_k;
        start_job(32'b11, 6'd2, 24'd1, 1'b1);
        repeat_en = 1'b0;
        for (int c = 0; c < 44; c++) begin
            exp_k = ((c % 18) < 4);
            checks++;
            if (key !== exp_k || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL repeat_c%0d got key=%b busy=%b done=%b want key=%b busy=1 done=0",
                         c, key, busy, done, exp_k);
            end
            @(negedge CLK);
        end
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        checks++;
        if ({busy, key, done, carrier_out} !== 4'b0) begin
            failures++;
            $display("FAIL abort_gap got=%b want=0000", {busy, key, done, carrier_out});
        end
        repeat (20) @(negedge CLK);
        checks++;
        if ({busy, key, done} !== 3'b0) begin
            failures++;
            $display("FAIL abort_stays_idle got=%b want=000", {busy, key, done});
        end
    endtask

    task automatic test_length_zero();
        start_job(32'hFFFF_FFFF, 6'd0, 24'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({busy, done, key} !== 3'b0) begin
                failures++;
                $display("FAIL len0_c%0d got=%b want=000", c, {busy, done, key});
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_clamp();
        logic [31:0] p;
        p = 32'hA5C3_0F96;
        start_job(p, 6'd40, 24'd0, 1'b0);
        for (int c = 0; c < 32; c++) begin
            checks++;
            if (key !== p[c] || busy !== 1'b1) begin
                failures++;
                $display("FAIL clamp_c%0d got key=%b busy=%b want key=%b busy=1", c, key, busy, p[c]);
            end
            @(negedge CLK);
        end
        checks++;
        if ({busy, key, done} !== 3'b001) begin
            failures++;
            $display("FAIL clamp_end got=%b want=001", {busy, key, done});
        end
        @(negedge CLK);
    endtask

    task automatic test_start_while_busy();
        logic [7:0] p;
        p = 8'b1101_0011;
        start_job(32'(p), 6'd8, 24'd1, 1'b0);
        for (int c = 0; c < 16; c++) begin
            if (c == 2) begin
                pattern = 32'(~p); length = 6'd3; unit_div = 24'd0; repeat_en = 1'b1; start = 1'b1;
            end
            if (c == 7) start = 1'b0;
            checks++;
            if (key !== p[c / 2] || busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_start_c%0d got key=%b busy=%b want key=%b busy=1", c, key, busy, p[c / 2]);
            end
            @(negedge CLK);
        end
        checks++;
        if ({busy, key, done} !== 3'b001) begin
            failures++;
            $display("FAIL busy_start_end got=%b want=001", {busy, key, done});
        end
        repeat_en = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_send();
        logic [7:0] p;
        p = 8'h4B;
        start_job(32'(p), 6'd8, 24'd2, 1'b0);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (key !== p[c / 3]) begin
                failures++;
                $display("FAIL rstmid_c%0d got=%b want=%b", c, key, p[c / 3]);
            end
            @(negedge CLK);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if ({busy, done, key, carrier_out, led} !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b want=00000", {busy, done, key, carrier_out, led});
        end
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({busy, done, key} !== 3'b0) begin
                failures++;
                $display("FAIL rstmid_after_c%0d got=%b want=000", c, {busy, done, key});
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_abort_with_start();
        abort = 1'b1;
        start_job(32'hF, 6'd4, 24'd0, 1'b0);
        abort = 1'b0;
        checks++;
        if ({busy, key} !== 2'b0) begin
            failures++;
            $display("FAIL abort_start got=%b want=00", {busy, key});
        end
        @(negedge CLK);
        checks++;
        if ({busy, key, done} !== 3'b0) begin
            failures++;
            $display("FAIL abort_start_next got=%b want=000", {busy, key, done});
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_single_bit();
        test_timed_pattern();
        test_repeat_abort();
        test_length_zero();
        test_clamp();
        test_start_while_busy();
        test_reset_mid_send();
        test_abort_with_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
